// File: rtl/irq_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : irq_controller_if
// Purpose  : Bundle of the sequencer-facing, register-bus and peripheral
//            signals of the interrupt controller. The master modport is the
//            driving side (sequencer / peripherals / bus host). The slave
//            modport is the controller itself.
// Revision : 1.0 - initial release
// ============================================================================
interface irq_controller_if #(
  parameter int N_IRQ = 5
);

  // Peripheral interrupt sources
  logic [N_IRQ-1:0] irq_trig;

  // Register bus
  logic [7:0]       wdata;
  logic             sel_if;
  logic             sel_ie;
  logic             wr;
  logic [7:0]       rdata;

  // Sequencer handshake
  logic             ime_set;
  logic             ime_clr;
  logic             m1;
  logic             int_ack;
  logic             irq_req;
  logic             wake;
  logic [15:0]      vector;
  logic             vector_valid;
  logic [N_IRQ-1:0] irq_ack;
  logic             ime;

  modport master (
    output irq_trig, wdata, sel_if, sel_ie, wr,
    output ime_set, ime_clr, m1, int_ack,
    input  rdata, irq_req, wake, vector, vector_valid, irq_ack, ime
  );

  modport slave (
    input  irq_trig, wdata, sel_if, sel_ie, wr,
    input  ime_set, ime_clr, m1, int_ack,
    output rdata, irq_req, wake, vector, vector_valid, irq_ack, ime
  );

endinterface
`default_nettype wire

// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
// Module   : irq_controller
// Purpose  : Prioritised interrupt controller. It holds interrupt flag (IF)
//            and enable (IE) registers, plus a master enable (IME) with a
//            delayed EI. A four-state dispatch FSM hands a vector to the
//            sequencer and acknowledges the serviced peripheral.
// Revision : 1.0 - initial release
// ============================================================================
module irq_controller #(
  parameter int               N_IRQ      = 5,        // 1..8 channels
  parameter logic [N_IRQ-1:0] LEVEL_MASK = '0,       // 1 = level, 0 = rising edge
  parameter logic [15:0]      VEC_BASE   = 16'h0040, // vector of channel 0
  parameter int               VEC_SHIFT  = 3         // vector stride = 2^VEC_SHIFT
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  irq_controller_if.slave  bus
);

  // --------------------------------------------------------------------------
  // Dispatch FSM encoding
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // waiting for an enabled pending interrupt with IME set
    ST_PEND = 2'd1,  // requesting dispatch from the sequencer
    ST_SNAP = 2'd2,  // choosing the winning channel and clearing its flag
    ST_VEC  = 2'd3   // presenting the vector for one cycle
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t           r_state;
  logic [N_IRQ-1:0] r_trig_prev;  // previous trigger sample for edge detection
  logic [N_IRQ-1:0] r_if;         // interrupt flags
  logic [7:0]       r_ie;         // interrupt enables (full byte is readable)
  logic             r_ime;        // master enable
  logic             r_ei_armed;   // EI seen, waiting for the next opcode fetch
  logic [2:0]       r_k;          // channel latched at the snapshot
  logic             r_hit;        // snapshot found a pending channel

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  state_t           w_state_next;
  logic             w_dispatch;
  logic             w_wr_if;
  logic             w_wr_ie;
  logic [N_IRQ-1:0] w_set;
  logic [N_IRQ-1:0] w_pend;
  logic             w_any_pend;
  logic [N_IRQ-1:0] w_if_eff;
  logic [N_IRQ-1:0] w_ie_eff;
  logic [N_IRQ-1:0] w_snap_pend;
  logic             w_snap_hit;
  logic [2:0]       w_snap_k;
  logic [N_IRQ-1:0] w_snap_clr;
  logic [N_IRQ-1:0] w_if_next;
  logic [7:0]       w_if_rd;
  logic [15:0]      w_vec_off;

  assign w_wr_if = bus.wr & bus.sel_if;
  assign w_wr_ie = bus.wr & bus.sel_ie;

  // Edge channels flag on a 0->1 transition; level channels flag while high.
  assign w_set = (bus.irq_trig & LEVEL_MASK)
               | (bus.irq_trig & ~r_trig_prev & ~LEVEL_MASK);

  // Pending set as seen from the registered state; drives WAKE and the FSM.
  assign w_pend     = r_if & r_ie[N_IRQ-1:0];
  assign w_any_pend = |w_pend;

  // The snapshot also sees a register write issued in the same cycle. This
  // lets software that disables or clears sources in the cycle right after
  // the acknowledge still cancel the dispatch.
  assign w_if_eff    = w_wr_if ? bus.wdata[N_IRQ-1:0] : r_if;
  assign w_ie_eff    = w_wr_ie ? bus.wdata[N_IRQ-1:0] : r_ie[N_IRQ-1:0];
  assign w_snap_pend = w_if_eff & w_ie_eff;
  assign w_snap_hit  = |w_snap_pend;

  // Lowest-index priority encoder over the snapshot pending set.
  always_comb begin
    w_snap_k = 3'd0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (w_snap_pend[i]) begin
        w_snap_k = 3'(i);
      end
    end
  end

  // One-hot clear of the winning flag, only when the snapshot found a winner.
  always_comb begin
    w_snap_clr = '0;
    if ((r_state == ST_SNAP) && w_snap_hit) begin
      for (int i = 0; i < N_IRQ; i++) begin
        w_snap_clr[i] = (w_snap_k == 3'(i));
      end
    end
  end

  // Next IF value: a bus write loads, trigger sets override the write, and
  // the dispatch clear overrides everything for the serviced bit.
  assign w_if_next = (w_if_eff | w_set) & ~w_snap_clr;

  // Read view of IF: unused upper bits read as 1.
  always_comb begin
    w_if_rd              = 8'hFF;
    w_if_rd[N_IRQ-1:0]   = r_if;
  end

  // Register read mux; selects are mutually exclusive, nothing selected reads 0.
  always_comb begin
    bus.rdata = 8'h00;
    if (bus.sel_if) begin
      bus.rdata = w_if_rd;
    end else if (bus.sel_ie) begin
      bus.rdata = r_ie;
    end
  end

  assign w_vec_off = 16'(r_k) << VEC_SHIFT;
  assign bus.wake  = w_any_pend;
  assign bus.ime   = r_ime;

  // --------------------------------------------------------------------------
  // Trigger history and flag/enable registers
  // --------------------------------------------------------------------------

  // Sample triggers and update IF / IE from sources, bus writes and dispatch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trig_prev <= '0;
      r_if        <= '0;
      r_ie        <= 8'h00;
    end else begin
      r_trig_prev <= bus.irq_trig;
      r_if        <= w_if_next;
      if (w_wr_ie) begin
        r_ie <= bus.wdata;
      end
    end
  end

  // Master enable: DI wins and cancels a pending EI; EI takes effect one
  // opcode fetch later; accepting a dispatch masks further interrupts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ime      <= 1'b0;
      r_ei_armed <= 1'b0;
    end else if (bus.ime_clr) begin
      r_ime      <= 1'b0;
      r_ei_armed <= 1'b0;
    end else begin
      r_ei_armed <= bus.ime_set | (r_ei_armed & ~bus.m1);
      if (w_dispatch) begin
        r_ime <= 1'b0;
      end else if (r_ei_armed && bus.m1) begin
        r_ime <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Dispatch FSM
  // --------------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Snapshot result, captured when leaving SNAP and held through VEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k   <= 3'd0;
      r_hit <= 1'b0;
    end else if (r_state == ST_SNAP) begin
      r_k   <= w_snap_k;
      r_hit <= w_snap_hit;
    end
  end

  // Next-state logic and sequencer-facing outputs.
  always_comb begin
    w_state_next     = r_state;
    w_dispatch       = 1'b0;
    bus.irq_req      = 1'b0;
    bus.vector_valid = 1'b0;
    bus.vector       = 16'h0000;
    bus.irq_ack      = '0;
    case (r_state)
      ST_IDLE: begin
        if (r_ime && w_any_pend) begin
          w_state_next = ST_PEND;
        end
      end
      ST_PEND: begin
        bus.irq_req = 1'b1;
        if (bus.int_ack) begin
          w_state_next = ST_SNAP;
          w_dispatch   = 1'b1;
        end else if (!(r_ime && w_any_pend)) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_SNAP: begin
        w_state_next = ST_VEC;
      end
      ST_VEC: begin
        bus.vector_valid = 1'b1;
        if (r_hit) begin
          bus.vector = VEC_BASE + w_vec_off;
          for (int i = 0; i < N_IRQ; i++) begin
            bus.irq_ack[i] = (r_k == 3'(i));
          end
        end
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_irq_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_controller
// Purpose  : Directed, table-driven bench for irq_controller (5 channels,
//            channel 2 level-sensitive), with hand-written dispatch sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_controller;

  localparam int N = 5;

  // Control field bits: {sel_if, sel_ie, wr, ime_set, ime_clr, m1, int_ack}
  localparam logic [6:0] C_SIF = 7'h40;
  localparam logic [6:0] C_SIE = 7'h20;
  localparam logic [6:0] C_WR  = 7'h10;
  localparam logic [6:0] C_SET = 7'h08;
  localparam logic [6:0] C_CLR = 7'h04;
  localparam logic [6:0] C_M1  = 7'h02;
  localparam logic [6:0] C_ACK = 7'h01;

  // Expected flag bits: {irq_req, wake, vector_valid, ime}
  localparam logic [3:0] F_REQ  = 4'h8;
  localparam logic [3:0] F_WAKE = 4'h4;
  localparam logic [3:0] F_VV   = 4'h2;
  localparam logic [3:0] F_IME  = 4'h1;

  typedef struct {
    logic [N-1:0] trig;
    logic [7:0]   wdata;
    logic [6:0]   ctrl;
    logic [7:0]   rdata;
    logic [3:0]   flags;
    logic [15:0]  vector;
    logic [N-1:0] ack;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  vec_t tbl [32];

  always #5 clk = ~clk;

  irq_controller_if #(.N_IRQ(N)) bus ();

  irq_controller #(
    .N_IRQ      (N),
    .LEVEL_MASK (5'b00100),
    .VEC_BASE   (16'h0040),
    .VEC_SHIFT  (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctrl(input logic [6:0] c);
    {bus.sel_if, bus.sel_ie, bus.wr, bus.ime_set, bus.ime_clr, bus.m1, bus.int_ack} = c;
  endtask

  // Bounded wait for the dispatch request; a timeout counts as a failure.
  task automatic wait_req();
    int n = 0;
    while (bus.irq_req !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk("irq_req_wait", 16'(bus.irq_req), 16'h0001);
  endtask

  // Enable interrupts through EI followed by one opcode fetch.
  task automatic enable_ime();
    set_ctrl(C_SET); tick();
    set_ctrl(C_M1);  tick();
    set_ctrl(7'h00); tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // trig, wdata, ctrl, rdata, flags, vector, ack
    tbl[0]  = '{5'h00, 8'h1F, C_SIE | C_WR, 8'h00, 4'h0, 16'h0000, 5'h00};
    tbl[1]  = '{5'h00, 8'h00, C_SET | C_SIE, 8'h1F, 4'h0, 16'h0000, 5'h00};
    tbl[2]  = '{5'h00, 8'h00, C_M1, 8'h00, 4'h0, 16'h0000, 5'h00};
    tbl[3]  = '{5'h00, 8'h00, C_SIF, 8'hE0, F_IME, 16'h0000, 5'h00};
    tbl[4]  = '{5'h06, 8'h00, 7'h00, 8'h00, F_IME, 16'h0000, 5'h00};
    tbl[5]  = '{5'h00, 8'h00, C_SIF, 8'hE6, F_IME | F_WAKE, 16'h0000, 5'h00};
    tbl[6]  = '{5'h00, 8'h00, C_ACK, 8'h00, F_REQ | F_WAKE | F_IME, 16'h0000, 5'h00};
    tbl[7]  = '{5'h00, 8'h00, 7'h00, 8'h00, F_WAKE, 16'h0000, 5'h00};
    tbl[8]  = '{5'h00, 8'h00, C_SIF, 8'hE4, F_WAKE | F_VV, 16'h0048, 5'h02};
    tbl[9]  = '{5'h00, 8'h00, C_SIF, 8'hE4, F_WAKE, 16'h0000, 5'h00};
    tbl[10] = '{5'h00, 8'h01, C_SIE | C_WR, 8'h1F, F_WAKE, 16'h0000, 5'h00};
    tbl[11] = '{5'h00, 8'h00, C_SIF | C_WR, 8'hE4, 4'h0, 16'h0000, 5'h00};
    tbl[12] = '{5'h01, 8'h00, 7'h00, 8'h00, 4'h0, 16'h0000, 5'h00};
    tbl[13] = '{5'h00, 8'h00, C_SIF, 8'hE1, F_WAKE, 16'h0000, 5'h00};
    tbl[14] = '{5'h01, 8'h00, C_SIF | C_WR, 8'hE1, F_WAKE, 16'h0000, 5'h00};
    tbl[15] = '{5'h00, 8'h00, C_SIF, 8'hE1, F_WAKE, 16'h0000, 5'h00};
    tbl[16] = '{5'h00, 8'h00, C_SIF | C_WR, 8'hE1, F_WAKE, 16'h0000, 5'h00};
    tbl[17] = '{5'h00, 8'h00, C_SIF, 8'hE0, 4'h0, 16'h0000, 5'h00};
    tbl[18] = '{5'h01, 8'h00, 7'h00, 8'h00, 4'h0, 16'h0000, 5'h00};
    tbl[19] = '{5'h01, 8'h00, C_SIF | C_WR, 8'hE1, F_WAKE, 16'h0000, 5'h00};
    tbl[20] = '{5'h01, 8'h00, C_SIF, 8'hE0, 4'h0, 16'h0000, 5'h00};
    tbl[21] = '{5'h00, 8'h00, C_SIF, 8'hE0, 4'h0, 16'h0000, 5'h00};
    tbl[22] = '{5'h00, 8'h00, C_SET | C_CLR, 8'h00, 4'h0, 16'h0000, 5'h00};
    tbl[23] = '{5'h00, 8'h00, C_M1, 8'h00, 4'h0, 16'h0000, 5'h00};
    tbl[24] = '{5'h00, 8'h00, 7'h00, 8'h00, 4'h0, 16'h0000, 5'h00};
    tbl[25] = '{5'h00, 8'h00, C_SET, 8'h00, 4'h0, 16'h0000, 5'h00};
    tbl[26] = '{5'h00, 8'h00, 7'h00, 8'h00, 4'h0, 16'h0000, 5'h00};
    tbl[27] = '{5'h00, 8'h00, 7'h00, 8'h00, 4'h0, 16'h0000, 5'h00};
    tbl[28] = '{5'h00, 8'h00, C_M1, 8'h00, 4'h0, 16'h0000, 5'h00};
    tbl[29] = '{5'h00, 8'h00, 7'h00, 8'h00, F_IME, 16'h0000, 5'h00};
    tbl[30] = '{5'h00, 8'h00, C_CLR, 8'h00, F_IME, 16'h0000, 5'h00};
    tbl[31] = '{5'h00, 8'h00, 7'h00, 8'h00, 4'h0, 16'h0000, 5'h00};

    // Reset and reset-state checks
    rst_n        = 1'b0;
    bus.irq_trig = '0;
    bus.wdata    = 8'h00;
    set_ctrl(7'h00);
    tick(); tick();
    chk("rst_irq_req", 16'(bus.irq_req), 16'h0000);
    chk("rst_wake",    16'(bus.wake), 16'h0000);
    chk("rst_vv",      16'(bus.vector_valid), 16'h0000);
    chk("rst_vector",  bus.vector, 16'h0000);
    chk("rst_ack",     16'(bus.irq_ack), 16'h0000);
    chk("rst_ime",     16'(bus.ime), 16'h0000);
    chk("rst_rd_none", 16'(bus.rdata), 16'h0000);
    set_ctrl(C_SIF); #1;
    chk("rst_rd_if",   16'(bus.rdata), 16'h00E0);
    set_ctrl(C_SIE); #1;
    chk("rst_rd_ie",   16'(bus.rdata), 16'h0000);
    set_ctrl(7'h00);
    tick();
    rst_n = 1'b1;

    // Table: drive one row per cycle, compare outputs in that cycle
    for (int r = 0; r < 32; r++) begin
      bus.irq_trig = tbl[r].trig;
      bus.wdata    = tbl[r].wdata;
      set_ctrl(tbl[r].ctrl);
      #1;
      chk($sformatf("row%0d_rdata", r),   16'(bus.rdata), 16'(tbl[r].rdata));
      chk($sformatf("row%0d_irq_req", r), 16'(bus.irq_req), 16'(tbl[r].flags[3]));
      chk($sformatf("row%0d_wake", r),    16'(bus.wake), 16'(tbl[r].flags[2]));
      chk($sformatf("row%0d_vv", r),      16'(bus.vector_valid), 16'(tbl[r].flags[1]));
      chk($sformatf("row%0d_ime", r),     16'(bus.ime), 16'(tbl[r].flags[0]));
      chk($sformatf("row%0d_vector", r),  bus.vector, tbl[r].vector);
      chk($sformatf("row%0d_ack", r),     16'(bus.irq_ack), 16'(tbl[r].ack));
      tick();
    end
    bus.irq_trig = '0;
    set_ctrl(7'h00);

    // Cancelled dispatch: IE cleared in the snapshot cycle
    bus.wdata = 8'h1F; set_ctrl(C_SIE | C_WR); tick();
    set_ctrl(7'h00);
    bus.irq_trig = 5'b00100; tick();
    bus.irq_trig = 5'b00000; tick();
    enable_ime();
    wait_req();
    set_ctrl(C_ACK); tick();
    chk("cancel_snap_vv", 16'(bus.vector_valid), 16'h0000);
    bus.wdata = 8'h00; set_ctrl(C_SIE | C_WR); tick();
    set_ctrl(7'h00);
    chk("cancel_vv",     16'(bus.vector_valid), 16'h0001);
    chk("cancel_vector", bus.vector, 16'h0000);
    chk("cancel_ack",    16'(bus.irq_ack), 16'h0000);
    chk("cancel_ime",    16'(bus.ime), 16'h0000);
    set_ctrl(C_SIF); #1;
    chk("cancel_if",     16'(bus.rdata), 16'h00E4);
    set_ctrl(7'h00);
    tick();
    chk("cancel_vv_end", 16'(bus.vector_valid), 16'h0000);

    // Level channel held through dispatch: cleared at SNAP, re-set next edge
    bus.wdata = 8'h04; set_ctrl(C_SIE | C_WR); tick();
    set_ctrl(7'h00);
    bus.irq_trig = 5'b00100;
    enable_ime();
    wait_req();
    set_ctrl(C_ACK); tick();
    set_ctrl(7'h00); tick();
    chk("lvl_vv",     16'(bus.vector_valid), 16'h0001);
    chk("lvl_vector", bus.vector, 16'h0050);
    chk("lvl_ack",    16'(bus.irq_ack), 16'h0004);
    set_ctrl(C_SIF); #1;
    chk("lvl_if_clr", 16'(bus.rdata), 16'h00E0);
    tick();
    chk("lvl_if_set", 16'(bus.rdata), 16'h00E4);
    chk("lvl_vv_end", 16'(bus.vector_valid), 16'h0000);
    set_ctrl(7'h00);

    // Reset asserted in the snapshot cycle aborts the dispatch
    enable_ime();
    wait_req();
    set_ctrl(C_ACK); tick();
    set_ctrl(C_SIF);
    chk("abort_snap_vv", 16'(bus.vector_valid), 16'h0000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_irq_req", 16'(bus.irq_req), 16'h0000);
    chk("abort_vv",      16'(bus.vector_valid), 16'h0000);
    chk("abort_vector",  bus.vector, 16'h0000);
    chk("abort_ack",     16'(bus.irq_ack), 16'h0000);
    chk("abort_wake",    16'(bus.wake), 16'h0000);
    chk("abort_ime",     16'(bus.ime), 16'h0000);
    chk("abort_rd_if",   16'(bus.rdata), 16'h00E0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("abort_hold%0d_vv", c), 16'(bus.vector_valid), 16'h0000);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("abort_rel%0d_vv", c),  16'(bus.vector_valid), 16'h0000);
      chk($sformatf("abort_rel%0d_req", c), 16'(bus.irq_req), 16'h0000);
      tick();
    end
    chk("abort_if_reset", 16'(bus.rdata), 16'h00E4);
    chk("abort_ie_wake",  16'(bus.wake), 16'h0000);
    set_ctrl(7'h00);
    bus.irq_trig = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 Parameter N_IRQ, default 5: number of interrupt channels, legal range 1..8.
REQ-002 Parameter LEVEL_MASK, default 0: per-channel mode, where bit=1 is level-sensitive and bit=0 is rising-edge.
REQ-003 Parameter VEC_BASE, default 16'h0040: vector of channel 0.
REQ-004 Parameter VEC_SHIFT, default 3: vector stride is 2^VEC_SHIFT bytes.
REQ-005 CLK  in  1  single clock; all state changes on rising edge.
REQ-006 nRESET  in  1  asynchronous, active-low reset.
REQ-007 IRQ_TRIG  in  N_IRQ  synchronous interrupt sources from peripherals.
REQ-008 WDATA  in  8  register write data.
REQ-009 SEL_IF / SEL_IE  in  1 each  register selects; at most one asserted at a time.
REQ-010 WR  in  1  write strobe, qualified by a select.
REQ-011 RDATA  out  8  combinational read of the selected register; 8'h00 when no select is asserted.
REQ-012 IME_SET / IME_CLR  in  1 each  EI / DI requests from the sequencer.
REQ-013 M1  in  1  one-cycle pulse at each opcode fetch.
REQ-014 INT_ACK  in  1  one-cycle pulse requesting interrupt dispatch.
REQ-015 IRQ_REQ  out  1  dispatch request to the sequencer.
REQ-016 WAKE  out  1  HALT/STOP wake request.
REQ-017 VECTOR  out  16  dispatch address.
REQ-018 VECTOR_VALID  out  1  one-cycle qualifier for VECTOR.
REQ-019 IRQ_ACK  out  N_IRQ  one-hot acknowledge to the serviced peripheral.
REQ-020 IME  out  1  master enable, visible for debug.

Function
REQ-021 IF[i], edge channel: set in the cycle after IRQ_TRIG[i] goes 0->1, detected against a registered previous value.
REQ-022 IF[i], level channel: set every cycle IRQ_TRIG[i]=1.
REQ-023 Write to IF: load WDATA[N_IRQ-1:0]; trigger set has priority over write-clear in the same cycle.
REQ-024 Write to IE: load all 8 bits of WDATA.
REQ-025 Read IF: {1 in bits 7..N_IRQ, IF}.
REQ-026 Read IE: full 8-bit register.
REQ-027 Pending: P = IF & IE[N_IRQ-1:0].
REQ-028 WAKE = |P, independent of IME and FSM state.
REQ-029 IME_CLR clears IME on the next edge and cancels any armed EI.
REQ-030 IME_SET arms EI; IME becomes 1 on the edge following the next M1 pulse (one-instruction delay).
REQ-031 IME_SET and IME_CLR in the same cycle: IME_CLR wins.
REQ-032 FSM states: IDLE, PEND, SNAP, VEC.
REQ-033 IDLE->PEND when IME & |P; IRQ_REQ=1 only in PEND.
REQ-034 PEND->IDLE if IME or |P drops before INT_ACK.
REQ-035 PEND->SNAP on INT_ACK; IME is cleared on that edge.
REQ-036 SNAP: re-evaluate P, select the lowest index k, latch k, clear IF[k] (clear wins over a same-cycle trigger set on bit k), go to VEC.
REQ-037 VEC, valid: VECTOR = VEC_BASE + (k<<VEC_SHIFT), VECTOR_VALID=1, IRQ_ACK[k]=1 for exactly one cycle, then IDLE.
REQ-038 VEC, cancelled (P was 0 at SNAP): VECTOR=16'h0000, VECTOR_VALID=1, IRQ_ACK=0, no IF bit cleared.
REQ-039 Latency: INT_ACK in cycle n gives VECTOR_VALID in cycle n+2.
REQ-040 INT_ACK outside PEND is ignored.
REQ-041 Vector arithmetic is 16-bit and wraps modulo 2^16.

Reset
REQ-042 nRESET low asynchronously forces IF=0, IE=0, IME=0, EI unarmed, previous-trigger register=0, FSM=IDLE, and all outputs to 0 (RDATA follows the select rule).
REQ-043 Reset asserted mid-dispatch aborts with no VECTOR_VALID pulse.
REQ-044 Release from reset is synchronous to the next CLK edge.

Verification
REQ-045 N_IRQ=5, IE=8'h1F, IME=1; pulse IRQ_TRIG=5'b00110 -> IRQ_REQ=1; INT_ACK -> two cycles later VECTOR=16'h0048, IRQ_ACK=5'b00010, IF reads 8'hE4, IME=0.
REQ-046 IME=1, IF[2] pending; write IE=0 in the cycle after INT_ACK -> VECTOR=16'h0000, VECTOR_VALID=1, IRQ_ACK=0, IF unchanged.
REQ-047 IME_SET, then M1 pulse three cycles later -> IME reads 0 until the edge after M1, then 1; IME_SET+IME_CLR together -> IME stays 0.
REQ-048 IME=0, IE=8'h01, trigger channel 0 -> WAKE=1, IRQ_REQ=0; write IF=0 in the same cycle as a new edge -> IF[0] remains 1.
REQ-049 LEVEL_MASK=5'b00100, hold IRQ_TRIG[2]=1 through dispatch -> IF[2] is cleared at SNAP and set again on the next edge; nRESET low mid-SNAP -> all outputs 0, no VECTOR_VALID.
